config_word_loader: RTL and testbench
=====================================

Name: config_word_loader

Overview:
- Consumes the 32-bit configuration words that the JTAG TAP emits on config_data/config_strobe while the PROGRAM instruction is active.
- Buffers the words in a small FIFO and writes them sequentially into the fabric configuration memory through a ready/valid write port.
- Holds the fabric in reset until a complete, error-free load has finished.
- Sits directly downstream of the TAP, in the tck domain.

Parameters:
- NUM_WORDS, 4, number of 32-bit words in a complete bitstream (16 bytes)
- ADDR_W, 8, configuration memory address width; NUM_WORDS <= 2**ADDR_W
- FIFO_DEPTH, 4, word FIFO depth; power of two, >= 2

Ports:
- tck  input  1  JTAG clock; all logic on posedge
- trst  input  1  asynchronous active-low reset
- active  input  1  TAP PROGRAM-instruction active level
- config_data  input  32  word from TAP, valid when config_strobe=1
- config_strobe  input  1  one-cycle word-valid pulse
- cfg_we  output  1  write request (valid)
- cfg_ready  input  1  config memory accepts write this cycle
- cfg_addr  output  ADDR_W  write address
- cfg_wdata  output  32  write data
- word_count  output  ADDR_W+1  words written to memory this load
- loaded  output  1  complete load done
- error  output  1  sticky load error
- fabric_reset_n  output  1  active-low fabric reset

Behaviour:
- Reset (trst=0, async) drives all outputs low:
  - cfg_we=0, cfg_addr=0, word_count=0, loaded=0, error=0, fabric_reset_n=0.
  - FIFO is empty, FSM=IDLE, active_q=0.
- active_q is active registered; rise = active & ~active_q; fall = ~active & active_q.
- FSM states: IDLE, LOAD, FLUSH, DONE, ERROR.
- Restart: rise, in any state, enters LOAD at that edge:
  - FIFO cleared; cfg_addr, word_count, loaded, error cleared; fabric_reset_n=0.
  - A config_strobe in the same cycle as rise is accepted as word 0, after the clear.
- Push:
  - Only in LOAD (including the rise cycle) with config_strobe=1.
  - config_strobe outside LOAD is ignored.
- Write side (LOAD and FLUSH):
  - cfg_we = FIFO not empty; cfg_wdata = FIFO head; cfg_addr = current write address.
  - A transfer occurs when cfg_we & cfg_ready; on a transfer: pop, cfg_addr+1, word_count+1.
  - cfg_we, cfg_addr and cfg_wdata hold stable while cfg_ready=0.
- Latency: a strobe at edge N into an empty FIFO gives cfg_we=1 after edge N; with cfg_ready=1, the write completes at edge N+1.
- Full FIFO:
  - A push while full, with no pop in the same cycle, is an overflow and goes to ERROR.
  - Push and pop together while full is legal: occupancy is unchanged.
- Excess: a push when words accepted this load already equals NUM_WORDS goes to ERROR; the word is dropped.
- LOAD -> FLUSH on fall. Strobes are ignored from the fall cycle onward.
- FLUSH:
  - Drains the FIFO, waiting indefinitely on cfg_ready.
  - When empty: word_count == NUM_WORDS -> DONE, otherwise ERROR (short load).
- DONE: loaded=1, fabric_reset_n=1; holds until rise or reset.
- ERROR:
  - error=1, fabric_reset_n=0, loaded=0, cfg_we=0; FIFO discarded.
  - Holds until rise or reset.
- IDLE: cfg_we=0, fabric_reset_n=0.
- Reset mid-load: immediate return to the reset state; no partial write completes.
- Address arithmetic: cfg_addr cannot wrap, because NUM_WORDS <= 2**ADDR_W and the excess check fires first.

Test Plan:
- Nominal load:
  - Stimulus: active=1; strobes with 0x01234567, 0x89ABCDEF, 0xDEADBEEF, 0x0BADF00D, 8 cycles apart; cfg_ready=1; then active=0.
  - Required: four writes at addr 0..3 with matching data, each one cycle after its strobe; then loaded=1, fabric_reset_n=1, error=0, word_count=4.
- Backpressure:
  - Stimulus: cfg_ready=0 for 20 cycles; 4 strobes on consecutive cycles.
  - Required: no overflow; cfg_we=1, cfg_addr=0, cfg_wdata=word0 held stable; when ready rises, 4 writes occur in order in 4 cycles; DONE.
- Overflow:
  - Stimulus: NUM_WORDS=8, FIFO_DEPTH=4, cfg_ready=0; 5 strobes.
  - Required: error=1 at the 5th push edge; cfg_we=0; fabric_reset_n=0.
- Short and excess loads:
  - Stimulus: 3 strobes then fall.
  - Required: after the drain, error=1, word_count=3, loaded=0.
  - Stimulus: 5 strobes.
  - Required: error on the 5th strobe.
- Restart and reset:
  - Stimulus: from ERROR, active 0->1.
  - Required: error=0, word_count=0, and a new nominal load succeeds.
  - Stimulus: trst=0 mid-LOAD with 2 words queued.
  - Required: all outputs 0 asynchronously; FIFO empty after release.
- Ignored strobes:
  - Stimulus: strobes while active=0 in IDLE or DONE.
  - Required: no cfg_we, and word_count and loaded are unchanged.

Source files
------------

// File: rtl/config_word_loader.sv
// config_word_loader
//   Receives 32-bit configuration words from the JTAG TAP while the PROGRAM
//   instruction is active, buffers them in a small FIFO and writes them in
//   order into the fabric configuration memory over a ready/valid port. The
//   fabric stays in reset until a complete, error-free load has been written.
//   Everything runs on posedge tck.
//
// Ports
//   tck            in   JTAG clock
//   trst           in   asynchronous active-low reset
//   active         in   PROGRAM instruction active level
//   config_data    in   32-bit word, qualified by config_strobe
//   config_strobe  in   one-cycle word-valid pulse
//   cfg_we         out  write request (valid)
//   cfg_ready      in   memory accepts the write this cycle
//   cfg_addr       out  write address
//   cfg_wdata      out  write data (FIFO head)
//   word_count     out  words written to memory during this load
//   loaded         out  complete load finished
//   error          out  sticky load error
//   fabric_reset_n out  active-low fabric reset
module config_word_loader #(
  parameter int NUM_WORDS  = 4,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              active,
  input  logic [31:0]       config_data,
  input  logic              config_strobe,
  output logic              cfg_we,
  input  logic              cfg_ready,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [31:0]       cfg_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              loaded,
  output logic              error,
  output logic              fabric_reset_n
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [WC_W-1:0]  ALL_WORDS = WC_W'(NUM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_active_q;
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [WC_W-1:0]   r_accepted;
  logic [ADDR_W-1:0] r_addr;
  logic [WC_W-1:0]   r_word_count;

  logic              w_rise;
  logic              w_fall;
  logic              w_draining;
  logic              w_push_req;
  logic              w_pop;
  logic              w_full;
  logic              w_excess;
  logic              w_overflow;
  logic              w_push;
  logic              w_fault;
  logic [PTR_W-1:0]  w_rd_eff;
  logic [PTR_W-1:0]  w_wr_eff;
  logic [CNT_W-1:0]  w_cnt_eff;
  logic [WC_W-1:0]   w_acc_eff;

  assign w_rise = active & ~r_active_q;
  assign w_fall = ~active & r_active_q;

  // A rising edge of active restarts the load: the FIFO and the accepted
  // count are treated as already cleared in the same cycle, so a strobe
  // coinciding with the rise lands as word 0 of the new load.
  assign w_rd_eff  = w_rise ? '0 : r_rd_ptr;
  assign w_wr_eff  = w_rise ? '0 : r_wr_ptr;
  assign w_cnt_eff = w_rise ? '0 : r_count;
  assign w_acc_eff = w_rise ? '0 : r_accepted;

  assign w_draining = (r_state == S_LOAD) || (r_state == S_FLUSH);
  assign cfg_we     = w_draining && (r_count != '0);
  assign cfg_wdata  = cfg_we ? r_mem[r_rd_ptr] : '0;
  assign cfg_addr   = r_addr;
  assign word_count = r_word_count;

  // A handshake in the restart cycle is discarded along with the FIFO.
  assign w_pop      = cfg_we && cfg_ready && !w_rise;

  // Strobes count only in LOAD (or the restart cycle) and never on a fall.
  assign w_push_req = config_strobe && (w_rise || ((r_state == S_LOAD) && !w_fall));
  assign w_full     = (w_cnt_eff == FULL_CNT);
  assign w_excess   = w_push_req && (w_acc_eff == ALL_WORDS);
  assign w_overflow = w_push_req && w_full && !w_pop;
  assign w_fault    = w_excess || w_overflow;
  assign w_push     = w_push_req && !w_fault;

  assign loaded         = (r_state == S_DONE);
  assign error          = (r_state == S_ERROR);
  assign fabric_reset_n = (r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    if (w_rise) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_fault)     w_state_nxt = S_ERROR;
          else if (w_fall) w_state_nxt = S_FLUSH;
        end
        S_FLUSH: begin
          if (r_count == '0)
            w_state_nxt = (r_word_count == ALL_WORDS) ? S_DONE : S_ERROR;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_state      <= S_IDLE;
      r_active_q   <= 1'b0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_accepted   <= '0;
      r_addr       <= '0;
      r_word_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_active_q <= active;

      if (w_rise) begin
        r_addr       <= '0;
        r_word_count <= '0;
      end else if (w_pop) begin
        r_addr       <= r_addr + ADDR_W'(1);
        r_word_count <= r_word_count + WC_W'(1);
      end

      // Entering or sitting in ERROR discards whatever is still queued.
      if (w_state_nxt == S_ERROR) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_rd_ptr <= w_rd_eff + PTR_W'(w_pop);
        r_wr_ptr <= w_wr_eff + PTR_W'(w_push);
        r_count  <= w_cnt_eff + CNT_W'(w_push) - CNT_W'(w_pop);
      end
      r_accepted <= w_acc_eff + WC_W'(w_push);
    end
  end

  // Word storage carries no reset; occupancy is tracked by r_count and the
  // read data is gated by cfg_we.
  always_ff @(posedge tck) begin
    if (w_push) r_mem[w_wr_eff] <= config_data;
  end

endmodule

// File: tb/tb_config_word_loader.sv
module tb_config_word_loader;

  logic        tck = 1'b0;
  logic        trst, active, config_strobe, cfg_ready;
  logic [31:0] config_data;

  logic        cfg_we, loaded, error, fabric_reset_n;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [8:0]  word_count;

  logic        cfg_we8, loaded8, error8, fabric_reset_n8;
  logic [7:0]  cfg_addr8;
  logic [31:0] cfg_wdata8;
  logic [8:0]  word_count8;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          mon_addr[$];
  logic [31:0] mon_data[$];
  int          mon_cyc[$];

  config_word_loader #(.NUM_WORDS(4), .ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .tck(tck), .trst(trst), .active(active), .config_data(config_data),
    .config_strobe(config_strobe), .cfg_we(cfg_we), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .word_count(word_count),
    .loaded(loaded), .error(error), .fabric_reset_n(fabric_reset_n)
  );

  config_word_loader #(.NUM_WORDS(8), .ADDR_W(8), .FIFO_DEPTH(4)) dut8 (
    .tck(tck), .trst(trst), .active(active), .config_data(config_data),
    .config_strobe(config_strobe), .cfg_we(cfg_we8), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr8), .cfg_wdata(cfg_wdata8), .word_count(word_count8),
    .loaded(loaded8), .error(error8), .fabric_reset_n(fabric_reset_n8)
  );

  always #5 tck = ~tck;

  always @(posedge tck) cyc <= cyc + 1;

  // Every handshake seen mid-cycle completes at the following posedge.
  always @(negedge tck) begin
    if (cfg_we === 1'b1 && cfg_ready === 1'b1) begin
      mon_addr.push_back(int'(cfg_addr));
      mon_data.push_back(cfg_wdata);
      mon_cyc.push_back(cyc);
    end
  end

  task automatic clk(input int n);
    repeat (n) @(posedge tck);
    #1;
  endtask

  task automatic strobe(input logic [31:0] d);
    config_data   = d;
    config_strobe = 1'b1;
    clk(1);
    config_strobe = 1'b0;
  endtask

  task automatic restart();
    active = 1'b0;
    clk(2);
    active = 1'b1;
    clk(1);
  endtask

  task automatic mon_clear();
    mon_addr.delete();
    mon_data.delete();
    mon_cyc.delete();
  endtask

  task automatic test_reset();
    trst = 1'b0; active = 1'b0; config_strobe = 1'b0; cfg_ready = 1'b0; config_data = '0;
    clk(2);
    n_tests++; if (cfg_we !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_we got %b want 0", cfg_we); end
    n_tests++; if (cfg_addr !== 8'd0) begin n_fail++; $display("FAIL reset_cfg_addr got %h want 0", cfg_addr); end
    n_tests++; if (cfg_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_cfg_wdata got %h want 0", cfg_wdata); end
    n_tests++; if (word_count !== 9'd0) begin n_fail++; $display("FAIL reset_word_count got %0d want 0", word_count); end
    n_tests++; if (loaded !== 1'b0) begin n_fail++; $display("FAIL reset_loaded got %b want 0", loaded); end
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
    n_tests++; if (fabric_reset_n !== 1'b0) begin n_fail++; $display("FAIL reset_fabric_reset_n got %b want 0", fabric_reset_n); end
    trst = 1'b1;
    clk(1);
    mon_clear();
    cfg_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobe($urandom);
      n_tests++; if (cfg_we !== 1'b0) begin n_fail++; $display("FAIL idle_ignore_we got %b want 0", cfg_we); end
      clk(1);
    end
    n_tests++; if (mon_addr.size() != 0) begin n_fail++; $display("FAIL idle_ignore_writes got %0d want 0", mon_addr.size()); end
    n_tests++; if ({loaded, word_count} !== 10'd0) begin n_fail++; $display("FAIL idle_ignore_status got %b/%0d want 0/0", loaded, word_count); end
  endtask

  task automatic test_nominal();
    logic [31:0] w [4];
    int sc [4];
    int k;
    w[0] = 32'h01234567; w[1] = 32'h89ABCDEF; w[2] = 32'hDEADBEEF; w[3] = 32'h0BADF00D;
    cfg_ready = 1'b1;
    restart();
    mon_clear();
    for (int i = 0; i < 4; i++) begin
      sc[i] = cyc;
      strobe(w[i]);
      clk(7);
    end
    active = 1'b0;
    k = 0;
    while (loaded !== 1'b1 && error !== 1'b1 && k < 40) begin clk(1); k++; end
    n_tests++; if (mon_addr.size() != 4) begin n_fail++; $display("FAIL nominal_write_count got %0d want 4", mon_addr.size()); end
    for (int i = 0; i < 4 && i < mon_addr.size(); i++) begin
      n_tests++; if (mon_addr[i] != i) begin n_fail++; $display("FAIL nominal_addr[%0d] got %0d want %0d", i, mon_addr[i], i); end
      n_tests++; if (mon_data[i] !== w[i]) begin n_fail++; $display("FAIL nominal_data[%0d] got %h want %h", i, mon_data[i], w[i]); end
      n_tests++; if (mon_cyc[i] != sc[i] + 1) begin n_fail++; $display("FAIL nominal_latency[%0d] got cycle %0d want %0d", i, mon_cyc[i], sc[i] + 1); end
    end
    n_tests++; if ({loaded, fabric_reset_n, error} !== 3'b110) begin n_fail++; $display("FAIL nominal_status got %b want 110", {loaded, fabric_reset_n, error}); end
    n_tests++; if (word_count !== 9'd4) begin n_fail++; $display("FAIL nominal_word_count got %0d want 4", word_count); end
  endtask

  task automatic test_ignored_done();
    mon_clear();
    for (int i = 0; i < 3; i++) begin
      strobe($urandom);
      n_tests++; if (cfg_we !== 1'b0) begin n_fail++; $display("FAIL done_ignore_we got %b want 0", cfg_we); end
      clk(2);
    end
    n_tests++; if (mon_addr.size() != 0) begin n_fail++; $display("FAIL done_ignore_writes got %0d want 0", mon_addr.size()); end
    n_tests++; if ({loaded, word_count} !== {1'b1, 9'd4}) begin n_fail++; $display("FAIL done_ignore_status got %b/%0d want 1/4", loaded, word_count); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [4];
    int k;
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    cfg_ready = 1'b0;
    active = 1'b0;
    clk(2);
    active = 1'b1;
    config_data = w[0];
    config_strobe = 1'b1;
    clk(1);
    config_strobe = 1'b0;
    for (int i = 1; i < 4; i++) strobe(w[i]);
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if ({cfg_we, cfg_addr, cfg_wdata, error} !== {1'b1, 8'd0, w[0], 1'b0}) begin
        n_fail++; $display("FAIL bp_hold got we=%b addr=%0d data=%h err=%b want we=1 addr=0 data=%h err=0", cfg_we, cfg_addr, cfg_wdata, error, w[0]);
      end
      clk(1);
    end
    mon_clear();
    cfg_ready = 1'b1;
    clk(6);
    n_tests++; if (mon_addr.size() != 4) begin n_fail++; $display("FAIL bp_write_count got %0d want 4", mon_addr.size()); end
    for (int i = 0; i < 4 && i < mon_addr.size(); i++) begin
      n_tests++;
      if (mon_addr[i] != i || mon_data[i] !== w[i] || mon_cyc[i] != mon_cyc[0] + i) begin
        n_fail++; $display("FAIL bp_write[%0d] got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d", i, mon_addr[i], mon_data[i], mon_cyc[i], i, w[i], mon_cyc[0] + i);
      end
    end
    active = 1'b0;
    k = 0;
    while (loaded !== 1'b1 && error !== 1'b1 && k < 40) begin clk(1); k++; end
    n_tests++; if ({loaded, error, word_count} !== {1'b1, 1'b0, 9'd4}) begin n_fail++; $display("FAIL bp_done got %b/%b/%0d want 1/0/4", loaded, error, word_count); end
  endtask

  task automatic test_overflow();
    cfg_ready = 1'b0;
    restart();
    for (int i = 0; i < 4; i++) strobe($urandom);
    n_tests++; if (error8 !== 1'b0) begin n_fail++; $display("FAIL overflow_early got error=%b want 0", error8); end
    strobe($urandom);
    n_tests++; if ({error8, cfg_we8, fabric_reset_n8} !== 3'b100) begin n_fail++; $display("FAIL overflow_error got err/we/frn=%b want 100", {error8, cfg_we8, fabric_reset_n8}); end
  endtask

  task automatic test_short();
    int k;
    cfg_ready = 1'b1;
    restart();
    for (int i = 0; i < 3; i++) begin strobe($urandom); clk(1); end
    active = 1'b0;
    k = 0;
    while (loaded !== 1'b1 && error !== 1'b1 && k < 40) begin clk(1); k++; end
    n_tests++; if ({error, loaded, fabric_reset_n} !== 3'b100) begin n_fail++; $display("FAIL short_status got err/ld/frn=%b want 100", {error, loaded, fabric_reset_n}); end
    n_tests++; if (word_count !== 9'd3) begin n_fail++; $display("FAIL short_word_count got %0d want 3", word_count); end
  endtask

  task automatic test_excess();
    cfg_ready = 1'b1;
    restart();
    mon_clear();
    for (int i = 0; i < 4; i++) begin strobe($urandom); clk(2); end
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL excess_early got error=%b want 0", error); end
    strobe($urandom);
    n_tests++; if ({error, cfg_we} !== 2'b10) begin n_fail++; $display("FAIL excess_error got err/we=%b want 10", {error, cfg_we}); end
    n_tests++; if (word_count !== 9'd4 || mon_addr.size() != 4) begin n_fail++; $display("FAIL excess_writes got wc=%0d writes=%0d want 4/4", word_count, mon_addr.size()); end
  endtask

  task automatic test_restart();
    logic [31:0] w [4];
    int k;
    active = 1'b0;
    clk(2);
    active = 1'b1;
    clk(1);
    n_tests++; if ({error, loaded, word_count} !== 11'd0) begin n_fail++; $display("FAIL restart_clear got %b/%b/%0d want 0/0/0", error, loaded, word_count); end
    mon_clear();
    cfg_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      strobe(w[i]);
      clk($urandom_range(0, 3));
    end
    active = 1'b0;
    k = 0;
    while (loaded !== 1'b1 && error !== 1'b1 && k < 40) begin clk(1); k++; end
    n_tests++; if ({loaded, error, fabric_reset_n} !== 3'b101) begin n_fail++; $display("FAIL restart_load got ld/err/frn=%b want 101", {loaded, error, fabric_reset_n}); end
    n_tests++; if (mon_data.size() != 4) begin n_fail++; $display("FAIL restart_write_count got %0d want 4", mon_data.size()); end
    for (int i = 0; i < 4 && i < mon_data.size(); i++) begin
      n_tests++; if (mon_data[i] !== w[i] || mon_addr[i] != i) begin n_fail++; $display("FAIL restart_write[%0d] got %0d:%h want %0d:%h", i, mon_addr[i], mon_data[i], i, w[i]); end
    end
  endtask

  task automatic test_reset_midload();
    cfg_ready = 1'b0;
    restart();
    strobe($urandom);
    strobe($urandom);
    n_tests++; if (cfg_we !== 1'b1) begin n_fail++; $display("FAIL midload_queued got we=%b want 1", cfg_we); end
    #2 trst = 1'b0;
    #1;
    n_tests++;
    if ({cfg_we, cfg_addr, cfg_wdata, word_count, loaded, error, fabric_reset_n} !== 53'd0) begin
      n_fail++; $display("FAIL midload_async_reset got we=%b addr=%0d data=%h wc=%0d ld=%b err=%b frn=%b want all 0",
                         cfg_we, cfg_addr, cfg_wdata, word_count, loaded, error, fabric_reset_n);
    end
    @(posedge tck);
    #1 trst = 1'b1;
    mon_clear();
    cfg_ready = 1'b1;
    clk(3);
    n_tests++; if (cfg_we !== 1'b0 || mon_addr.size() != 0) begin n_fail++; $display("FAIL midload_fifo_empty got we=%b writes=%0d want 0/0", cfg_we, mon_addr.size()); end
    n_tests++; if (word_count !== 9'd0) begin n_fail++; $display("FAIL midload_word_count got %0d want 0", word_count); end
  endtask

  // Reference: the FIFO is a queue; a write happens whenever something is
  // queued, the load is live and ready is high; strobes are admitted only
  // while loading and within the word budget and free space.
  task automatic test_random();
    logic [31:0] q[$];
    logic [8:0]  m_wcnt;
    int          acc, phase, target, sent, sz;
    bit          fell, st, rdy, do_fall, pop, exp_we, finished;
    for (int ld = 0; ld < 8; ld++) begin
      restart();
      q.delete();
      m_wcnt = '0; acc = 0; phase = 0; sent = 0; fell = 1'b0; finished = 1'b0;
      target = $urandom_range(2, 6);
      for (int c = 0; c < 150; c++) begin
        exp_we = (phase < 2) && (q.size() > 0);
        n_tests++; if (cfg_we !== exp_we) begin n_fail++; $display("FAIL rand_we load %0d cyc %0d got %b want %b", ld, c, cfg_we, exp_we); end
        if (exp_we) begin
          n_tests++;
          if ({cfg_addr, cfg_wdata} !== {m_wcnt[7:0], q[0]}) begin
            n_fail++; $display("FAIL rand_port load %0d cyc %0d got %0d:%h want %0d:%h", ld, c, cfg_addr, cfg_wdata, m_wcnt[7:0], q[0]);
          end
        end
        n_tests++;
        if ({loaded, error, word_count} !== {phase == 2, phase == 3, m_wcnt}) begin
          n_fail++; $display("FAIL rand_status load %0d cyc %0d got %b/%b/%0d want %b/%b/%0d", ld, c, loaded, error, word_count, phase == 2, phase == 3, m_wcnt);
        end
        if (phase >= 2) begin finished = 1'b1; break; end
        st = 1'b0; do_fall = 1'b0;
        if (!fell) begin
          if (sent < target) st = ($urandom_range(0, 1) == 0);
          else do_fall = ($urandom_range(0, 3) == 0);
        end
        if (st) sent++;
        if (do_fall) fell = 1'b1;
        rdy = ($urandom_range(0, 3) != 0);
        config_data = $urandom;
        config_strobe = st;
        cfg_ready = rdy;
        if (do_fall) active = 1'b0;
        sz = q.size();
        pop = (phase < 2) && (sz > 0) && rdy;
        if (pop) begin void'(q.pop_front()); m_wcnt = m_wcnt + 9'd1; end
        if (phase == 0) begin
          if (do_fall) phase = 1;
          else if (st) begin
            if (acc == 4 || (sz == 4 && !pop)) phase = 3;
            else begin q.push_back(config_data); acc++; end
          end
        end else if (phase == 1 && sz == 0) begin
          phase = (m_wcnt == 9'd4) ? 2 : 3;
        end
        if (phase == 3) q.delete();
        clk(1);
        config_strobe = 1'b0;
      end
      n_tests++; if (!finished) begin n_fail++; $display("FAIL rand_timeout load %0d got no terminal state want done/error", ld); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ignored_done();
    test_backpressure();
    test_overflow();
    test_short();
    test_excess();
    test_restart();
    test_reset_midload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
